// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
//   Shared types and constants for the shift-subtract divider sequencer.
//   - div_state_e : controller state encoding (IDLE/LOAD/RUN/DONE)
//   - DIV_WIDTH   : default operand width (iteration count)
//   - DIV_CNT_W   : default iteration counter width (2**DIV_CNT_W > DIV_WIDTH)
//   - DIV_TERM    : terminal iteration index, DIV_WIDTH-1
package div_ctrl_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = 6;
   localparam int unsigned DIV_TERM  = DIV_WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// div_iter_counter
//   Iteration counter for the divider sequencer.
//   Ports:
//     clk_i      : clock, rising edge
//     rst_i      : synchronous active-high reset, count -> 0
//     clear_i    : load count with 0 (priority over enable)
//     enable_i   : advance count by one per cycle
//     count_o    : current iteration index
//     terminal_o : count_o == WIDTH-1
//   The count saturates at WIDTH-1 so it holds the last index after a run.
module div_iter_counter
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [CNT_W-1:0] count_o,
   output logic             terminal_o
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign terminal_o = (count_q == TERM);
   assign count_o    = count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !terminal_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/divider_controller.sv
// divider_controller
//   Sequencing FSM for the multi-cycle shift-subtract divider.
//   IDLE -> LOAD (one div_rst strobe) -> RUN (WIDTH div_run cycles) -> DONE
//   (one-cycle done pulse) -> IDLE. start is only sampled in IDLE.
//   Ports:
//     clk     : clock, rising edge
//     rst     : synchronous active-high reset
//     start   : division request (IDLE only)
//     divisor : divisor operand, used only for the zero check
//     busy    : high in LOAD, RUN and DONE
//     done    : one-cycle completion pulse
//     div_rst : reset/load strobe to the datapath (also high during rst)
//     div_run : iteration enable to the Remainder register
//     iter    : current iteration index
//     dz_err  : divide-by-zero flag (only with DIVZERO_CHECK_EN)
//   Build option: define DIVZERO_CHECK_EN to short-circuit a zero divisor
//   straight from IDLE to DONE with dz_err set.
module divider_controller
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_rst,
   output logic             div_run,
   output logic [CNT_W-1:0] iter
`ifdef DIVZERO_CHECK_EN
   ,
   output logic             dz_err
`endif
);

   div_state_e state_q;
   div_state_e state_d;
   logic       terminal;
   logic       div_zero;

`ifdef DIVZERO_CHECK_EN
   logic dz_q;
   logic dz_d;

   assign div_zero = (divisor == '0);
   assign dz_err   = dz_q;
`else
   logic unused_divisor;

   assign div_zero       = 1'b0;
   assign unused_divisor = ^divisor;
`endif

   div_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (state_q == S_LOAD),
      .enable_i   (state_q == S_RUN),
      .count_o    (iter),
      .terminal_o (terminal)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = div_zero ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            if (terminal) begin
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef DIVZERO_CHECK_EN
   // Flag is registered on the accept edge so it lines up with the DONE cycle.
   always_comb begin
      dz_d = 1'b0;
      if (state_q == S_IDLE && start && div_zero) begin
         dz_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dz_q <= 1'b0;
      end else begin
         dz_q <= dz_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign div_run = (state_q == S_RUN);
   assign div_rst = rst | (state_q == S_LOAD);

endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller
//   Directed self-checking bench for divider_controller (WIDTH=32, CNT_W=6).
//   Covers reset, nominal run, ignored start, mid-run reset, zero divisor
//   (with and without DIVZERO_CHECK_EN) and back-to-back operation.
module tb_divider_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_rst;
   logic        div_run;
   logic [5:0]  iter;
`ifdef DIVZERO_CHECK_EN
   logic        dz_err;
`endif

   int total = 0;
   int bad   = 0;

   int n_rst, n_run, n_done, n_dz;
   int first_done, last_done, bad_iter, busy_after;

   always #5 clk = ~clk;

   divider_controller #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .divisor (divisor),
      .busy    (busy),
      .done    (done),
      .div_rst (div_rst),
      .div_run (div_run),
      .iter    (iter)
`ifdef DIVZERO_CHECK_EN
      ,
      .dz_err  (dz_err)
`endif
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps ncyc cycles, tallying outputs. Cycle 1 is the cycle after the
   // first edge. Optional stimulus: start at a RUN iteration, start in DONE,
   // rst at a RUN iteration, or start held high throughout.
   task automatic watch(input int ncyc, input int st_iter, input bit st_done,
                        input int rst_iter, input bit hold);
      int exp_iter;
      n_rst = 0; n_run = 0; n_done = 0; n_dz = 0;
      first_done = -1; last_done = -1; bad_iter = 0; busy_after = 1;
      exp_iter = 0;
      for (int c = 1; c <= ncyc; c++) begin
         step();
         if (div_rst) begin
            n_rst++;
            exp_iter = 0;
         end
         if (div_run) begin
            if (int'(iter) != exp_iter) bad_iter++;
            exp_iter++;
            n_run++;
         end
         if (last_done > 0 && c == last_done + 1) busy_after = int'(busy);
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = c;
            last_done = c;
         end
`ifdef DIVZERO_CHECK_EN
         if (dz_err) n_dz++;
`endif
         rst   = (rst_iter >= 0) && div_run && (int'(iter) == rst_iter);
         start = hold || ((st_iter >= 0) && div_run && (int'(iter) == st_iter))
                      || (st_done && done);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b1;
      divisor = 32'h0000_0007;

      // Reset with start asserted
      step();
      step();
      check("rst_busy",   int'(busy),    0);
      check("rst_done",   int'(done),    0);
      check("rst_run",    int'(div_run), 0);
      check("rst_iter",   int'(iter),    0);
      check("rst_divrst", int'(div_rst), 1);
      start = 1'b0;
      rst   = 1'b0;
      step();
      check("post_rst_divrst", int'(div_rst), 0);
      check("post_rst_busy",   int'(busy),    0);
`ifdef DIVZERO_CHECK_EN
      check("post_rst_dz", int'(dz_err), 0);
`endif

      // Nominal
      divisor = 32'h0000_0007;
      start   = 1'b1;
      watch(40, -1, 1'b0, -1, 1'b0);
      check("nom_rst_cycles", n_rst,      1);
      check("nom_run_cycles", n_run,      32);
      check("nom_iter_seq",   bad_iter,   0);
      check("nom_dones",      n_done,     1);
      check("nom_done_at",    first_done, 34);
      check("nom_busy_fall",  busy_after, 0);
      check("nom_iter_hold",  int'(iter), 31);
      check("nom_idle_busy",  int'(busy), 0);

      // Start re-asserted in RUN (iter 10) and in DONE is ignored
      start = 1'b1;
      watch(50, 10, 1'b1, -1, 1'b0);
      check("ign_dones",      n_done,     1);
      check("ign_run_cycles", n_run,      32);
      check("ign_rst_cycles", n_rst,      1);
      check("ign_done_at",    first_done, 34);

      // Reset at iter 15 aborts the run
      start = 1'b1;
      watch(40, -1, 1'b0, 15, 1'b0);
      check("abort_run_cycles", n_run,      16);
      check("abort_dones",      n_done,     0);
      check("abort_divrst",     n_rst,      2);
      check("abort_busy",       int'(busy), 0);
      check("abort_iter",       int'(iter), 0);
      start = 1'b1;
      watch(40, -1, 1'b0, -1, 1'b0);
      check("fresh_done_at",    first_done, 34);
      check("fresh_run_cycles", n_run,      32);
      check("fresh_iter_seq",   bad_iter,   0);

      // Zero divisor
      divisor = '0;
      start   = 1'b1;
`ifdef DIVZERO_CHECK_EN
      watch(5, -1, 1'b0, -1, 1'b0);
      check("dz_done_at", first_done, 1);
      check("dz_dones",   n_done,     1);
      check("dz_runs",    n_run,      0);
      check("dz_divrst",  n_rst,      0);
      check("dz_flag",    n_dz,       1);
`else
      watch(40, -1, 1'b0, -1, 1'b0);
      check("dz_done_at", first_done, 34);
      check("dz_runs",    n_run,      32);
      check("dz_dones",   n_done,     1);
`endif

      // Back-to-back with start held high
      divisor = 32'h0000_0003;
      start   = 1'b1;
      watch(105, -1, 1'b0, -1, 1'b1);
      check("b2b_dones",      n_done,     3);
      check("b2b_run_cycles", n_run,      96);
      check("b2b_loads",      n_rst,      3);
      check("b2b_first_done", first_done, 34);
      check("b2b_last_done",  last_done,  104);
      check("b2b_iter_seq",   bad_iter,   0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
